max_pool_2x2: RTL and testbench

- 2x2 stride-2 max-pooling stage directly downstream of the 3x3 Laplacian convolution stage.
- Consumes the convolution's clamped pixel stream: one pixel per clock while valid is high, gaps allowed between pixels.
- Emits one pooled pixel per 2x2 block, halving width and height of the edge map before the next CNN layer.
- Stores one half-width row of pair-maxima internally, so the upstream stage needs no extra buffering.

---
 rtl/max_pool_2x2.sv | 80 ++++++++
 tb/tb_max_pool_2x2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max-pooling stage for the convolution's clamped pixel stream.
// Keeps one half-width row of horizontal pair maxima and emits one pooled pixel per block.
module max_pool_2x2 #(
   parameter int WORD_SIZE = 8,
   parameter int IN_COLS   = 538
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] in_pixel,
   input  logic                 in_valid,
   input  logic                 in_sof,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_valid,
   output logic                 out_eol
);

   localparam int OUT_COLS = IN_COLS / 2;
   localparam int CW       = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
   localparam int AW       = (CW > 1) ? CW - 1 : 1;
   localparam bit ODD_COLS = (IN_COLS % 2) != 0;
   localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);
   localparam logic [AW-1:0] LAST_OUT = AW'(OUT_COLS - 1);

   logic [CW-1:0]        col_reg, col_next, col_cur;
   logic                 parity_reg, parity_next, parity_cur;
   logic [WORD_SIZE-1:0] pair_reg, pair_max, buf_rd_reg;
   logic [WORD_SIZE-1:0] row_buf [OUT_COLS];
   logic [AW-1:0]        addr;
   logic                 pool_col, buf_wr, buf_rd, emit;

   // in_sof overrides the counter state for the pixel it arrives with
   always_comb begin
      col_cur    = in_sof ? '0 : col_reg;
      parity_cur = in_sof ? 1'b0 : parity_reg;
      addr       = AW'(col_cur >> 1);
      pool_col   = !(ODD_COLS && (col_cur == LAST_COL));
      pair_max   = (in_pixel > pair_reg) ? in_pixel : pair_reg;
      buf_rd     = in_valid && pool_col && !col_cur[0] && parity_cur;
      buf_wr     = in_valid && pool_col &&  col_cur[0] && !parity_cur;
      emit       = in_valid && pool_col &&  col_cur[0] &&  parity_cur;
      col_next    = col_cur + CW'(1);
      parity_next = parity_cur;
      if (col_cur == LAST_COL) begin
         col_next    = '0;
         parity_next = !parity_cur;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_reg    <= '0;
         parity_reg <= 1'b0;
         pair_reg   <= '0;
         out_pixel  <= '0;
         out_valid  <= 1'b0;
         out_eol    <= 1'b0;
      end else begin
         out_valid <= emit;
         out_eol   <= emit && (addr == LAST_OUT);
         if (in_valid) begin
            col_reg    <= col_next;
            parity_reg <= parity_next;
            if (pool_col && !col_cur[0])
               pair_reg <= in_pixel;
         end
         if (emit)
            out_pixel <= (buf_rd_reg > pair_max) ? buf_rd_reg : pair_max;
      end
   end

   // Bottom-row entry is prefetched on the even pixel of the pair, so the single
   // port sees a read on even/bottom pixels and a write on odd/top pixels only.
   always_ff @(posedge clk) begin
      if (buf_wr)
         row_buf[addr] <= pair_max;
      if (buf_rd)
         buf_rd_reg <= row_buf[addr];
   end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: three instances (4, 5 and 538 columns) checked every cycle
// against a frame-indexed 2x2 max reference model.
module tb_max_pool_2x2;

   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NI-1:0]      vld, sof, ov, oe;
   logic [NI-1:0][7:0] pix, opix;

   int n_checks = 0;
   int n_pass   = 0;
   int out_cnt [NI];
   int eol_cnt [NI];

   // reference model state
   bit ev [NI];
   bit ee [NI];
   int ep [NI];
   int pos [NI];
   int img [NI][2][538];

   always #5 clk = ~clk;

   function automatic int ncol(int k);
      return (k == 0) ? 4 : (k == 1) ? 5 : 538;
   endfunction

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         max_pool_2x2 #(
            .WORD_SIZE (8),
            .IN_COLS   ((gi == 0) ? 4 : (gi == 1) ? 5 : 538)
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_pixel  (pix[gi]),
            .in_valid  (vld[gi]),
            .in_sof    (sof[gi]),
            .out_pixel (opix[gi]),
            .out_valid (ov[gi]),
            .out_eol   (oe[gi])
         );
      end
   endgenerate

   // Pixels are placed in a two-row image by their frame position; a block's output
   // is due one clock after its bottom-right pixel.
   always @(posedge clk or negedge rst) begin
      int r, c, n;
      for (int k = 0; k < NI; k++) begin
         if (!rst) begin
            pos[k] = 0;
            ev[k]  = 1'b0;
            ee[k]  = 1'b0;
            ep[k]  = 0;
         end else begin
            ev[k] = 1'b0;
            ee[k] = 1'b0;
            if (vld[k]) begin
               if (sof[k]) pos[k] = 0;
               n = ncol(k);
               r = pos[k] / n;
               c = pos[k] % n;
               img[k][r % 2][c] = int'(pix[k]);
               if ((r % 2 == 1) && (c % 2 == 1) && (c < 2 * (n / 2))) begin
                  ep[k] = max2(max2(img[k][0][c-1], img[k][0][c]),
                               max2(img[k][1][c-1], img[k][1][c]));
                  ev[k] = 1'b1;
                  ee[k] = (c == 2 * (n / 2) - 1);
               end
               pos[k]++;
            end
         end
      end
   end

   task automatic check(string tag, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   task automatic monitor();
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d_valid", k), int'(ov[k]), int'(ev[k]));
         check($sformatf("u%0d_pixel", k), int'(opix[k]), ep[k]);
         check($sformatf("u%0d_eol", k), int'(oe[k]), int'(ee[k]));
         if (ov[k]) out_cnt[k]++;
         if (oe[k]) eol_cnt[k]++;
      end
   endtask

   // inputs change at the falling edge, right after outputs are compared
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic idle(int n);
      repeat (n) cyc();
   endtask

   task automatic px(int k, int v, bit s);
      pix[k] = 8'(v);
      vld[k] = 1'b1;
      sof[k] = s;
      cyc();
      vld[k] = 1'b0;
      sof[k] = 1'b0;
   endtask

   int t1 [8]  = '{10, 20, 30, 5, 1, 2, 40, 3};
   int t3 [10] = '{9, 1, 2, 8, 255, 0, 0, 0, 0, 255};

   initial begin
      vld = '0;
      sof = '0;
      pix = '0;
      for (int k = 0; k < NI; k++) begin
         out_cnt[k] = 0;
         eol_cnt[k] = 0;
      end

      // asynchronous reset before any clock edge
      #1 rst = 1'b0;
      #1;
      check("rst_valid", int'(ov[0]), 0);
      check("rst_pixel", int'(opix[2]), 0);
      check("rst_eol", int'(oe[1]), 0);
      idle(2);
      rst = 1'b1;
      idle(1);

      // 4 columns, continuous
      for (int i = 0; i < 8; i++) begin
         px(0, t1[i], i == 0);
         if (i == 5) check("t1_first", int'(opix[0]), 20);
         if (i == 7) begin
            check("t1_second", int'(opix[0]), 40);
            check("t1_eol", int'(oe[0]), 1);
         end
      end
      idle(1);

      // same data with a gap after every pixel
      for (int i = 0; i < 8; i++) begin
         px(0, t1[i], i == 0);
         if (i == 5) check("t2_first", int'(opix[0]), 20);
         cyc();
         if (i == 5) begin
            check("t2_hold_pix", int'(opix[0]), 20);
            check("t2_hold_valid", int'(ov[0]), 0);
         end
         if (i == 7) check("t2_second", int'(opix[0]), 40);
      end

      // 5 columns: last column dropped
      for (int i = 0; i < 10; i++) begin
         px(1, t3[i], i == 0);
         if (i == 6) check("t3_first", int'(opix[1]), 9);
         if (i == 8) begin
            check("t3_second", int'(opix[1]), 8);
            check("t3_eol", int'(oe[1]), 1);
         end
      end
      idle(1);
      check("t3_no255", int'(opix[1]), 8);

      // partial data, then start of frame
      out_cnt[0] = 0;
      for (int i = 0; i < 3; i++) px(0, $urandom_range(0, 255), 1'b0);
      for (int i = 0; i < 8; i++) px(0, 7, i == 0);
      check("t4_pixel", int'(opix[0]), 7);
      check("t4_eol", int'(oe[0]), 1);
      check("t4_count", out_cnt[0], 2);

      // reset in the middle of the bottom row
      for (int i = 0; i < 6; i++) px(0, $urandom_range(1, 255), i == 0);
      check("t5_pre_valid", int'(ov[0]), 1);
      rst = 1'b0;
      #1;
      check("t5_valid", int'(ov[0]), 0);
      check("t5_pixel", int'(opix[0]), 0);
      check("t5_eol", int'(oe[0]), 0);
      idle(2);
      rst = 1'b1;
      out_cnt[0] = 0;
      for (int i = 0; i < 8; i++) px(0, $urandom_range(0, 255), 1'b0);
      idle(1);
      check("t5_count", out_cnt[0], 2);

      // full-width random frame of 4 rows
      out_cnt[2] = 0;
      eol_cnt[2] = 0;
      for (int i = 0; i < 4 * 538; i++) px(2, $urandom_range(0, 255), i == 0);
      idle(1);
      check("t6_count", out_cnt[2], 538);
      check("t6_eol", eol_cnt[2], 2);

      // small random frames with random gaps
      for (int k = 0; k < 2; k++) begin
         for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4 * ncol(k); i++) begin
               px(k, $urandom_range(0, 255), i == 0);
               idle($urandom_range(0, 2));
            end
         end
      end
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
